// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 subset controller: opcodes, FSM states and
// datapath select codes that the ALU control decoder and datapath agree on.
package rv_ctrl_pkg;

    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StTrap   = 4'd9
    } state_e;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAReg   = 2'b01;
    localparam logic [1:0] SrcAOldPc = 2'b10;

    localparam logic [1:0] SrcBReg  = 2'b00;
    localparam logic [1:0] SrcBFour = 2'b01;
    localparam logic [1:0] SrcBImm  = 2'b10;

    localparam logic PcSrcAlu    = 1'b0;
    localparam logic PcSrcAluOut = 1'b1;

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_mem_state(state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the shared datapath (slave).
interface multicycle_ctrl_if;

    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       retire;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a, alu_src_b,
               alu_op, pc_src, reg_write, mem_to_reg, retire, trap, trap_cause
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a, alu_src_b,
               alu_op, pc_src, reg_write, mem_to_reg, retire, trap, trap_cause
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Stall watchdog: counts cycles spent waiting on mem_ready and flags the last allowed one.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TCW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [TCW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable && (TIMEOUT != 0)) begin
            count_q <= count_q + TCW'(1);
        end
    end

    // Fires on the wait cycle that brings the count to TIMEOUT; TIMEOUT=0 disables it.
    assign expired = (TIMEOUT != 0) && enable && (count_q == TCW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32 subset core (ADD/SUB/AND/OR, LW, SW, BEQ).
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    state_e     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       waiting;
    logic       expired;

    assign waiting = is_mem_state(state_q) && !bus.mem_ready;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!waiting),
        .enable  (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cause_q <= CauseNone;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            StFetch, StMemRd, StMemWr: begin
                if (bus.mem_ready) begin
                    state_d = (state_q == StFetch) ? StDecode :
                              (state_q == StMemRd) ? StMemWb  : StFetch;
                end else if (expired) begin
                    state_d = StTrap;
                    cause_d = CauseTimeout;
                end
            end
            StDecode: begin
                case (bus.opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExec;
                    OpBranch:        state_d = StBranch;
                    default: begin
                        state_d = StTrap;
                        cause_d = CauseIllegal;
                    end
                endcase
            end
            StMemAdr: state_d = (bus.opcode == OpLoad) ? StMemRd : StMemWr;
            StMemWb:  state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch;
        endcase
    end

    logic       pc_write, ir_write, mem_read, mem_write, i_or_d;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       pc_src, reg_write, mem_to_reg, retire, trap;
    logic [1:0] trap_cause;

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBReg;
        alu_op     = AluOpAdd;
        pc_src     = PcSrcAlu;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        trap_cause = CauseNone;
        // Reset masks everything so an aborted access cannot write or retire.
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = SrcBFour;
                    ir_write  = bus.mem_ready;
                    pc_write  = bus.mem_ready;
                end
                StDecode: begin
                    alu_src_a = SrcAOldPc;
                    alu_src_b = SrcBImm;
                end
                StMemAdr: begin
                    alu_src_a = SrcAReg;
                    alu_src_b = SrcBImm;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                StMemWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    retire    = bus.mem_ready;
                end
                StExec: begin
                    alu_src_a = SrcAReg;
                    alu_op    = AluOpFunct;
                end
                StAluWb: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                StBranch: begin
                    alu_src_a = SrcAReg;
                    alu_op    = AluOpSub;
                    pc_src    = PcSrcAluOut;
                    pc_write  = bus.zero;
                    retire    = 1'b1;
                end
                StTrap: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write   = pc_write;
    assign bus.ir_write   = ir_write;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.i_or_d     = i_or_d;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.pc_src     = pc_src;
    assign bus.reg_write  = reg_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.retire     = retire;
    assign bus.trap       = trap;
    assign bus.trap_cause = trap_cause;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-vector bench for multicycle_ctrl with a small watchdog limit (TIMEOUT=4).
module tb_multicycle_ctrl;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] BQ = 7'b1100011;
    localparam logic [6:0] IL = 7'b0010011;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       retire;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [6:0] opcode;
        logic       zero;
        logic       ready;
        outs_t      exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(
        .TIMEOUT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t  vecs[$];
    outs_t sb[$];
    int    total = 0;
    int    bad   = 0;

    function automatic outs_t o_none();
        outs_t o = '0;
        return o;
    endfunction
    function automatic outs_t o_fetch(logic rdy);
        outs_t o = '0;
        o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction
    function automatic outs_t o_decode();
        outs_t o = '0;
        o.alu_src_a = 2'b10; o.alu_src_b = 2'b10;
        return o;
    endfunction
    function automatic outs_t o_memadr();
        outs_t o = '0;
        o.alu_src_a = 2'b01; o.alu_src_b = 2'b10;
        return o;
    endfunction
    function automatic outs_t o_memrd();
        outs_t o = '0;
        o.mem_read = 1'b1; o.i_or_d = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_memwb();
        outs_t o = '0;
        o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.retire = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_memwr(logic rdy);
        outs_t o = '0;
        o.mem_write = 1'b1; o.i_or_d = 1'b1; o.retire = rdy;
        return o;
    endfunction
    function automatic outs_t o_exec();
        outs_t o = '0;
        o.alu_src_a = 2'b01; o.alu_op = 2'b10;
        return o;
    endfunction
    function automatic outs_t o_aluwb();
        outs_t o = '0;
        o.reg_write = 1'b1; o.retire = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_branch(logic z);
        outs_t o = '0;
        o.alu_src_a = 2'b01; o.alu_op = 2'b01; o.pc_src = 1'b1; o.pc_write = z; o.retire = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_trap(logic [1:0] cause);
        outs_t o = '0;
        o.trap = 1'b1; o.trap_cause = cause;
        return o;
    endfunction

    function automatic void add(string name, logic r, logic [6:0] op, logic z, logic rdy,
                                outs_t e);
        vec_t v;
        v.name = name; v.rst = r; v.opcode = op; v.zero = z; v.ready = rdy; v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.pc_write   = bus.pc_write;
        o.ir_write   = bus.ir_write;
        o.mem_read   = bus.mem_read;
        o.mem_write  = bus.mem_write;
        o.i_or_d     = bus.i_or_d;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.alu_op     = bus.alu_op;
        o.pc_src     = bus.pc_src;
        o.reg_write  = bus.reg_write;
        o.mem_to_reg = bus.mem_to_reg;
        o.retire     = bus.retire;
        o.trap       = bus.trap;
        o.trap_cause = bus.trap_cause;
        return o;
    endfunction

    task automatic latency(string name, logic [6:0] op, int want);
        int  n    = 0;
        bit  done = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            rst = 1'b0; bus.opcode = op; bus.mem_ready = 1'b1; bus.zero = 1'b0;
            n++;
            #1;
            if (bus.retire === 1'b1) done = 1'b1;
        end
        total++;
        if (!done || n != want) begin
            bad++;
            $display("FAIL latency_%s got=%0d cycles (retired=%0b) want=%0d", name, n, done, want);
        end
    endtask

    initial begin
        outs_t got, e;
        bus.opcode = R; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        add("rst", 1, R, 0, 1, o_none());
        add("rst", 1, R, 0, 1, o_none());
        // R-type, zero-wait memory
        add("r_fetch", 0, R, 0, 1, o_fetch(1));
        add("r_decode", 0, R, 0, 1, o_decode());
        add("r_exec", 0, R, 0, 1, o_exec());
        add("r_aluwb", 0, R, 0, 1, o_aluwb());
        // LW, two wait cycles on fetch and on the data read
        add("lw_fetch_w", 0, LW, 0, 0, o_fetch(0));
        add("lw_fetch_w", 0, LW, 0, 0, o_fetch(0));
        add("lw_fetch", 0, LW, 0, 1, o_fetch(1));
        add("lw_decode", 0, LW, 0, 0, o_decode());
        add("lw_memadr", 0, LW, 0, 0, o_memadr());
        add("lw_memrd_w", 0, LW, 0, 0, o_memrd());
        add("lw_memrd_w", 0, LW, 0, 0, o_memrd());
        add("lw_memrd", 0, LW, 0, 1, o_memrd());
        add("lw_memwb", 0, LW, 0, 0, o_memwb());
        // BEQ taken, then not taken (mem_ready high outside memory states is ignored)
        add("bq1_fetch", 0, BQ, 1, 1, o_fetch(1));
        add("bq1_decode", 0, BQ, 1, 1, o_decode());
        add("bq1_branch", 0, BQ, 1, 1, o_branch(1));
        add("bq0_fetch", 0, BQ, 0, 1, o_fetch(1));
        add("bq0_decode", 0, BQ, 0, 1, o_decode());
        add("bq0_branch", 0, BQ, 0, 1, o_branch(0));
        // SW zero-wait
        add("sw_fetch", 0, SW, 0, 1, o_fetch(1));
        add("sw_decode", 0, SW, 0, 1, o_decode());
        add("sw_memadr", 0, SW, 0, 1, o_memadr());
        add("sw_memwr", 0, SW, 0, 1, o_memwr(1));
        // SW completing exactly on the 4th wait cycle: no trap
        add("sw4_fetch", 0, SW, 0, 1, o_fetch(1));
        add("sw4_decode", 0, SW, 0, 0, o_decode());
        add("sw4_memadr", 0, SW, 0, 0, o_memadr());
        for (int i = 0; i < 3; i++) add("sw4_memwr_w", 0, SW, 0, 0, o_memwr(0));
        add("sw4_memwr_last", 0, SW, 0, 1, o_memwr(1));
        // LW aborted by reset during MEMRD wait, then an R-type
        add("rlw_fetch", 0, LW, 0, 1, o_fetch(1));
        add("rlw_decode", 0, LW, 0, 0, o_decode());
        add("rlw_memadr", 0, LW, 0, 0, o_memadr());
        add("rlw_memrd_w", 0, LW, 0, 0, o_memrd());
        add("rlw_abort", 1, LW, 0, 1, o_none());
        add("rlw_refetch_w", 0, R, 0, 0, o_fetch(0));
        add("rlw_refetch", 0, R, 0, 1, o_fetch(1));
        add("rlw_r_decode", 0, R, 0, 1, o_decode());
        add("rlw_r_exec", 0, R, 0, 1, o_exec());
        add("rlw_r_aluwb", 0, R, 0, 1, o_aluwb());
        // SW aborted by reset in the cycle mem_ready arrives: no retire escapes
        add("rsw_fetch", 0, SW, 0, 1, o_fetch(1));
        add("rsw_decode", 0, SW, 0, 1, o_decode());
        add("rsw_memadr", 0, SW, 0, 1, o_memadr());
        add("rsw_memwr_w", 0, SW, 0, 0, o_memwr(0));
        add("rsw_abort", 1, SW, 0, 1, o_none());
        // SW watchdog expiry after 4 wait cycles
        add("to_fetch", 0, SW, 0, 1, o_fetch(1));
        add("to_decode", 0, SW, 0, 0, o_decode());
        add("to_memadr", 0, SW, 0, 0, o_memadr());
        for (int i = 0; i < 4; i++) add("to_memwr_w", 0, SW, 0, 0, o_memwr(0));
        add("to_trap", 0, SW, 1, 1, o_trap(2'b10));
        add("to_trap", 0, SW, 0, 0, o_trap(2'b10));
        add("to_trap", 0, R, 1, 1, o_trap(2'b10));
        add("to_rst", 1, R, 0, 0, o_none());
        // Fetch watchdog expiry
        for (int i = 0; i < 4; i++) add("fto_fetch_w", 0, R, 0, 0, o_fetch(0));
        add("fto_trap", 0, R, 0, 1, o_trap(2'b10));
        add("fto_rst", 1, R, 0, 0, o_none());
        // Illegal opcode: absorbing trap for 20 cycles, then reset
        add("il_fetch", 0, IL, 0, 1, o_fetch(1));
        add("il_decode", 0, IL, 0, 1, o_decode());
        for (int i = 0; i < 20; i++) add("il_trap", 0, IL, i[0], i[1], o_trap(2'b01));
        add("il_rst", 1, IL, 1, 1, o_none());
        add("il_refetch", 0, R, 0, 0, o_fetch(0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            bus.opcode    = vecs[i].opcode;
            bus.zero      = vecs[i].zero;
            bus.mem_ready = vecs[i].ready;
            sb.push_back(vecs[i].exp);
            #1;
            got = sample();
            e   = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s (vec %0d) got=%05h want=%05h", vecs[i].name, i, got, e);
            end
        end

        // Zero-wait latencies, each starting from FETCH
        latency("rtype", R, 4);
        latency("beq", BQ, 3);
        latency("sw", SW, 4);
        latency("lw", LW, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32 subset core: R-type ADD/SUB/AND/OR, LW, SW, BEQ.
- Sequences fetch/decode/execute/memory/writeback over the shared datapath: one ALU, one unified memory port, PC, IR, A/B/ALUOut/MDR registers.
- Drives ALUOp into the ALU control decoder; the decoder combines ALUOp with {funct3, funct7}.
- Handles a variable-latency memory port with a ready handshake and a stall watchdog.

Parameters:
- TIMEOUT, 255, max cycles to wait for mem_ready in any memory state; 0 disables the watchdog.
- TCW, $clog2(TIMEOUT+1), watchdog counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0], stable from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  load PC
- ir_write  out  1  load IR (and old_pc)
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut
- alu_src_a  out  2  00 PC, 01 A, 10 old_pc
- alu_src_b  out  2  00 B, 01 const 4, 10 imm
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- pc_src  out  1  0 = ALU result, 1 = ALUOut
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- retire  out  1  one-cycle pulse when an instruction completes
- trap  out  1  sticky fault flag
- trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none

Behaviour:
Reset and output timing
- While rst=1: state <= FETCH, watchdog <= 0, trap <= 0, trap_cause <= 00.
- While rst=1 every output is forced to 0, regardless of the other inputs.
- The first fetch request appears in the first cycle after rst deasserts.
- rst asserted mid-access aborts the access immediately; no write or retire escapes in that cycle.
- Outputs are decoded from the registered state. Only pc_write, ir_write, reg_write and retire may also depend on inputs; those are listed below.
- Any output not listed for a state is 0.

Opcodes
- R-type 0110011, LW 0000011, SW 0100011, BEQ 1100011.

States and outputs
- FETCH: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_src=0.
  - ir_write = pc_write = mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE: alu_src_a=10, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - LW or SW -> MEMADR; R-type -> EXEC; BEQ -> BRANCH.
  - Any other opcode -> TRAP, cause 01.
- MEMADR: alu_src_a=01, alu_src_b=10, alu_op=00.
  - LW -> MEMRD; SW -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1.
  - mem_ready=1 -> MEMWB; otherwise stay.
- MEMWB: reg_write=1, mem_to_reg=1, retire=1 -> FETCH.
- MEMWR: mem_write=1, i_or_d=1.
  - retire = mem_ready; mem_ready=1 -> FETCH; otherwise stay.
- EXEC: alu_src_a=01, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB: reg_write=1, mem_to_reg=0, retire=1 -> FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_src=1.
  - pc_write = zero; retire=1 -> FETCH.
- TRAP: all outputs 0 except trap=1 and trap_cause. Absorbing until rst.

Memory handshake and watchdog
- mem_read and mem_write stay held until mem_ready. They are never both 1.
- The watchdog clears on entry to FETCH, MEMRD or MEMWR, and increments each cycle those states wait with mem_ready=0.
- If the count reaches TIMEOUT while mem_ready=0 -> TRAP, cause 10.
- mem_ready=1 on the same cycle the count reaches TIMEOUT counts as a completed access (no trap).
- mem_ready arriving outside a memory state is ignored.

Latency (zero-wait memory)
- R-type 4 cycles, BEQ 3, SW 4, LW 5.
- Each wait cycle on mem_ready adds one cycle.

Decomposition:
- Shared package (rv_ctrl_pkg):
  - opcode constants
  - state enum (4-bit encoding)
  - ALUOp codes, matching the ALU control decoder: 00 add, 01 sub, 10 funct
  - alu_src_a / alu_src_b / pc_src select codes
  - trap_cause codes
- One sub-module: mem_wait_timer (clear, enable, TIMEOUT-parameterised counter, expired flag).
- State register and output decode stay in multicycle_ctrl.

Test Plan:
- R-type: rst 2 cycles, then mem_ready=1 always, opcode=0110011.
  - States FETCH,DECODE,EXEC,ALUWB; alu_op=10 in EXEC.
  - reg_write=1 and retire=1 in cycle 4; back in FETCH in cycle 5.
- LW with 3-cycle memory: mem_ready low 2 cycles in both FETCH and MEMRD, opcode=0000011.
  - mem_read held 3 cycles in each state; ir_write pulses once.
  - mem_to_reg=1 and reg_write=1 in cycle 9.
- BEQ: opcode=1100011, zero=1 -> pc_write=1, pc_src=1, alu_op=01 in cycle 3.
  - Repeat with zero=0 -> pc_write=0; retire=1 in both cases.
- Illegal opcode 0010011: TRAP entered after DECODE with trap=1, trap_cause=01.
  - All other outputs stay 0 for 20 cycles; rst returns to FETCH with trap=0.
- Timeout: TIMEOUT=4, SW, mem_ready held 0 in MEMWR.
  - TRAP with cause 10 after 4 wait cycles; mem_write drops to 0 and no retire.
  - Repeat with mem_ready=1 on the 4th wait cycle -> no trap, retire=1.
- Reset mid-MEMRD: assert rst during the MEMRD wait.
  - Next cycle all outputs 0, no reg_write; FETCH is issued the first cycle after rst releases.
